// File: rtl/ff_pair_monitor.sv
// Monitors a complementary Q/Qbar pair from an asynchronous-preset/clear flop:
// synchronises, glitch-filters, classifies LOW/HIGH/FAULT and counts accepted edges.
module ff_pair_monitor #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FILT_LEN    = 4,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             C,
  input  logic             CLRB,
  input  logic             Q_IN,
  input  logic             QBAR_IN,
  input  logic             EN,
  input  logic             CNT_CLR,
  output logic             Q_FILT,
  output logic             RISE,
  output logic             FALL,
  output logic [CNT_W-1:0] RISE_CNT,
  output logic [CNT_W-1:0] FALL_CNT,
  output logic             PAIR_ERR,
  output logic [1:0]       STATE
);

  localparam int unsigned FCW = $clog2(FILT_LEN + 1);
  localparam logic [FCW-1:0]   FILT_MAX = FCW'(FILT_LEN);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  typedef enum logic [1:0] {
    ST_INIT  = 2'b00,
    ST_LOW   = 2'b01,
    ST_HIGH  = 2'b10,
    ST_FAULT = 2'b11
  } state_e;

  // Synchroniser chains, one per input bit, independent of EN
  logic [SYNC_STAGES-1:0] sq_q, sq_d;
  logic [SYNC_STAGES-1:0] sqb_q, sqb_d;
  logic [1:0]             pair_s;

  always_comb begin
    sq_d  = {sq_q[SYNC_STAGES-2:0], Q_IN};
    sqb_d = {sqb_q[SYNC_STAGES-2:0], QBAR_IN};
  end

  always_ff @(posedge C) begin
    if (!CLRB) begin
      sq_q  <= '0;
      sqb_q <= '0;
    end else begin
      sq_q  <= sq_d;
      sqb_q <= sqb_d;
    end
  end

  assign pair_s = {sq_q[SYNC_STAGES-1], sqb_q[SYNC_STAGES-1]};

  // Glitch filter: candidate tracks the synchronised pair, count measures its run length
  logic [1:0]     cand_q, cand_d;
  logic [FCW-1:0] fcnt_q, fcnt_d;
  logic           filt_ok;

  always_comb begin
    cand_d  = pair_s;
    fcnt_d  = '0;
    filt_ok = 1'b0;
    if (EN) begin
      if (pair_s != cand_q) begin
        fcnt_d = FCW'(1);
      end else if (fcnt_q != FILT_MAX) begin
        fcnt_d = fcnt_q + FCW'(1);
      end else begin
        fcnt_d = fcnt_q;
      end
      filt_ok = (fcnt_d == FILT_MAX);
    end
  end

  always_ff @(posedge C) begin
    if (!CLRB) begin
      cand_q <= '0;
      fcnt_q <= '0;
    end else begin
      cand_q <= cand_d;
      fcnt_q <= fcnt_d;
    end
  end

  // Pair classification
  state_e pair_cls;

  always_comb begin
    pair_cls = ST_FAULT;
    case (pair_s)
      2'b01:   pair_cls = ST_LOW;
      2'b10:   pair_cls = ST_HIGH;
      default: pair_cls = ST_FAULT;
    endcase
  end

  // FSM state register
  state_e state_q, state_d;

  always_ff @(posedge C) begin
    if (!CLRB) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and registered-output next values
  logic             q_filt_q, q_filt_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] rise_cnt_q, rise_cnt_d;
  logic [CNT_W-1:0] fall_cnt_q, fall_cnt_d;
  logic             err_q, err_d;
  logic             accept;

  always_comb begin
    state_d    = state_q;
    q_filt_d   = q_filt_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    rise_cnt_d = CNT_CLR ? '0 : rise_cnt_q;
    fall_cnt_d = CNT_CLR ? '0 : fall_cnt_q;
    err_d      = CNT_CLR ? 1'b0 : err_q;
    accept     = filt_ok && (pair_cls != state_q);

    if (accept) begin
      state_d = pair_cls;
      case (pair_cls)
        ST_LOW: begin
          q_filt_d = 1'b0;
          if (state_q == ST_HIGH) begin
            fall_d = 1'b1;
            if (fall_cnt_d != CNT_MAX) fall_cnt_d = fall_cnt_d + CNT_W'(1);
          end
        end
        ST_HIGH: begin
          q_filt_d = 1'b1;
          if (state_q == ST_LOW) begin
            rise_d = 1'b1;
            if (rise_cnt_d != CNT_MAX) rise_cnt_d = rise_cnt_d + CNT_W'(1);
          end
        end
        ST_FAULT: begin
          err_d = 1'b1;
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  always_ff @(posedge C) begin
    if (!CLRB) begin
      q_filt_q   <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      rise_cnt_q <= '0;
      fall_cnt_q <= '0;
      err_q      <= 1'b0;
    end else begin
      q_filt_q   <= q_filt_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      rise_cnt_q <= rise_cnt_d;
      fall_cnt_q <= fall_cnt_d;
      err_q      <= err_d;
    end
  end

  assign Q_FILT   = q_filt_q;
  assign RISE     = rise_q;
  assign FALL     = fall_q;
  assign RISE_CNT = rise_cnt_q;
  assign FALL_CNT = fall_cnt_q;
  assign PAIR_ERR = err_q;
  assign STATE    = state_q;

endmodule

// File: tb/tb_ff_pair_monitor.sv
// Bench for ff_pair_monitor: directed vector table, hand sequences and a
// randomized run scored against a sample-window reference model.
module tb_ff_pair_monitor;

  localparam int SYNC = 2;
  localparam int FL   = 4;

  logic C = 1'b0;
  logic CLRB = 1'b0, Q_IN = 1'b0, QBAR_IN = 1'b0, EN = 1'b1, CNT_CLR = 1'b0;

  logic       qf8, rise8, fall8, err8;
  logic [7:0] rc8, fc8;
  logic [1:0] st8;
  logic       qf4, rise4, fall4, err4;
  logic [3:0] rc4, fc4;
  logic [1:0] st4;

  ff_pair_monitor u_dut8 (
    .C(C), .CLRB(CLRB), .Q_IN(Q_IN), .QBAR_IN(QBAR_IN), .EN(EN), .CNT_CLR(CNT_CLR),
    .Q_FILT(qf8), .RISE(rise8), .FALL(fall8), .RISE_CNT(rc8), .FALL_CNT(fc8),
    .PAIR_ERR(err8), .STATE(st8)
  );

  ff_pair_monitor #(.CNT_W(4)) u_dut4 (
    .C(C), .CLRB(CLRB), .Q_IN(Q_IN), .QBAR_IN(QBAR_IN), .EN(EN), .CNT_CLR(CNT_CLR),
    .Q_FILT(qf4), .RISE(rise4), .FALL(fall4), .RISE_CNT(rc4), .FALL_CNT(fc4),
    .PAIR_ERR(err4), .STATE(st4)
  );

  always #5 C = ~C;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: a pair is accepted once the last FL synchronised samples
  // were all taken with EN high and all equal; the synchroniser is a pure delay.
  logic [1:0] rawq[$];
  logic [2:0] win[$];
  int m_st = 0, m_qf = 0, m_rise = 0, m_fall = 0, m_err = 0;
  int m_r8 = 0, m_f8 = 0, m_r4 = 0, m_f4 = 0;

  task automatic model_step();
    logic [1:0] s;
    bit ok;
    int c;
    if (!CLRB) begin
      rawq.delete();
      for (int i = 0; i < SYNC; i++) rawq.push_back(2'b00);
      win.delete();
      m_st = 0; m_qf = 0; m_rise = 0; m_fall = 0; m_err = 0;
      m_r8 = 0; m_f8 = 0; m_r4 = 0; m_f4 = 0;
      return;
    end
    s = rawq.pop_front();
    rawq.push_back({Q_IN, QBAR_IN});
    win.push_back({EN, s});
    if (win.size() > FL) void'(win.pop_front());
    ok = (win.size() == FL);
    foreach (win[i]) if (win[i] != {1'b1, s}) ok = 0;
    m_rise = 0;
    m_fall = 0;
    if (CNT_CLR) begin
      m_r8 = 0; m_f8 = 0; m_r4 = 0; m_f4 = 0; m_err = 0;
    end
    c = (s == 2'b01) ? 1 : (s == 2'b10) ? 2 : 3;
    if (ok && c != m_st) begin
      if (m_st == 1 && c == 2) begin
        m_rise = 1;
        if (m_r8 < 255) m_r8++;
        if (m_r4 < 15) m_r4++;
      end
      if (m_st == 2 && c == 1) begin
        m_fall = 1;
        if (m_f8 < 255) m_f8++;
        if (m_f4 < 15) m_f4++;
      end
      if (c == 3) m_err = 1;
      else m_qf = (c == 2) ? 1 : 0;
      m_st = c;
    end
  endtask

  // Scoreboard: every cycle, both instances against the model
  always begin
    @(posedge C);
    model_step();
    #1;
    chk("sb_state8", 32'(st8),   32'(m_st));
    chk("sb_qf8",    32'(qf8),   32'(m_qf));
    chk("sb_rise8",  32'(rise8), 32'(m_rise));
    chk("sb_fall8",  32'(fall8), 32'(m_fall));
    chk("sb_rcnt8",  32'(rc8),   32'(m_r8));
    chk("sb_fcnt8",  32'(fc8),   32'(m_f8));
    chk("sb_err8",   32'(err8),  32'(m_err));
    chk("sb_state4", 32'(st4),   32'(m_st));
    chk("sb_qf4",    32'(qf4),   32'(m_qf));
    chk("sb_rise4",  32'(rise4), 32'(m_rise));
    chk("sb_fall4",  32'(fall4), 32'(m_fall));
    chk("sb_rcnt4",  32'(rc4),   32'(m_r4));
    chk("sb_fcnt4",  32'(fc4),   32'(m_f4));
    chk("sb_err4",   32'(err4),  32'(m_err));
  end

  typedef struct {
    logic q, qb, en, clr, rstn;
    int   n;
    int   st, qf, rise, fall, rcnt, fcnt, err;
  } vec_t;

  vec_t vt[24];

  function automatic vec_t mk(input logic q, input logic qb, input logic en,
                              input logic clr, input logic rstn, input int n,
                              input int st, input int qf, input int rise, input int fall,
                              input int rcnt, input int fcnt, input int err);
    vec_t v;
    v.q = q; v.qb = qb; v.en = en; v.clr = clr; v.rstn = rstn; v.n = n;
    v.st = st; v.qf = qf; v.rise = rise; v.fall = fall;
    v.rcnt = rcnt; v.fcnt = fcnt; v.err = err;
    return v;
  endfunction

  task automatic hold(input logic q, input logic qb, input logic en,
                      input logic clr, input logic rstn, input int n);
    for (int j = 0; j < n; j++) begin
      @(negedge C);
      Q_IN = q; QBAR_IN = qb; EN = en; CNT_CLR = clr; CLRB = rstn;
    end
    @(posedge C);
    #2;
  endtask

  initial begin
    //           q  qb en clr rst n   st qf ri fa rc fc er
    vt[0]  = mk(0, 1, 1, 0, 1, 5,  0, 0, 0, 0, 0, 0, 0);
    vt[1]  = mk(0, 1, 1, 0, 1, 1,  1, 0, 0, 0, 0, 0, 0);
    vt[2]  = mk(1, 0, 1, 0, 1, 5,  1, 0, 0, 0, 0, 0, 0);
    vt[3]  = mk(1, 0, 1, 0, 1, 1,  2, 1, 1, 0, 1, 0, 0);
    vt[4]  = mk(1, 0, 1, 0, 1, 1,  2, 1, 0, 0, 1, 0, 0);
    vt[5]  = mk(0, 1, 1, 0, 1, 6,  1, 0, 0, 1, 1, 1, 0);
    vt[6]  = mk(0, 1, 1, 0, 1, 1,  1, 0, 0, 0, 1, 1, 0);
    vt[7]  = mk(1, 0, 1, 0, 1, 6,  2, 1, 1, 0, 2, 1, 0);
    vt[8]  = mk(0, 1, 1, 0, 1, 3,  2, 1, 0, 0, 2, 1, 0);
    vt[9]  = mk(1, 0, 1, 0, 1, 6,  2, 1, 0, 0, 2, 1, 0);
    vt[10] = mk(0, 1, 1, 0, 1, 4,  2, 1, 0, 0, 2, 1, 0);
    vt[11] = mk(1, 0, 1, 0, 1, 1,  2, 1, 0, 0, 2, 1, 0);
    vt[12] = mk(1, 0, 1, 0, 1, 1,  1, 0, 0, 1, 2, 2, 0);
    vt[13] = mk(1, 0, 1, 0, 1, 4,  2, 1, 1, 0, 3, 2, 0);
    vt[14] = mk(1, 1, 1, 0, 1, 10, 3, 1, 0, 0, 3, 2, 1);
    vt[15] = mk(0, 1, 1, 0, 1, 10, 1, 0, 0, 0, 3, 2, 1);
    vt[16] = mk(1, 0, 1, 0, 1, 5,  1, 0, 0, 0, 3, 2, 1);
    vt[17] = mk(1, 0, 1, 1, 1, 1,  2, 1, 1, 0, 1, 0, 0);
    vt[18] = mk(0, 1, 0, 0, 1, 20, 2, 1, 0, 0, 1, 0, 0);
    vt[19] = mk(0, 1, 1, 0, 1, 3,  2, 1, 0, 0, 1, 0, 0);
    vt[20] = mk(0, 1, 1, 0, 1, 1,  1, 0, 0, 1, 1, 1, 0);
    vt[21] = mk(1, 0, 1, 0, 1, 4,  1, 0, 0, 0, 1, 1, 0);
    vt[22] = mk(1, 0, 1, 0, 0, 1,  0, 0, 0, 0, 0, 0, 0);
    vt[23] = mk(1, 0, 1, 0, 1, 6,  2, 1, 0, 0, 0, 0, 0);

    // Initial reset
    @(posedge C);
    @(posedge C);
    #2;
    chk("rst_state", 32'(st8), 32'(0));
    chk("rst_qf",    32'(qf8), 32'(0));
    chk("rst_rcnt",  32'(rc8), 32'(0));
    chk("rst_err",   32'(err8), 32'(0));

    foreach (vt[i]) begin
      hold(vt[i].q, vt[i].qb, vt[i].en, vt[i].clr, vt[i].rstn, vt[i].n);
      chk($sformatf("vec%0d_state", i), 32'(st8),   32'(vt[i].st));
      chk($sformatf("vec%0d_qf", i),    32'(qf8),   32'(vt[i].qf));
      chk($sformatf("vec%0d_rise", i),  32'(rise8), 32'(vt[i].rise));
      chk($sformatf("vec%0d_fall", i),  32'(fall8), 32'(vt[i].fall));
      chk($sformatf("vec%0d_rcnt", i),  32'(rc8),   32'(vt[i].rcnt));
      chk($sformatf("vec%0d_fcnt", i),  32'(fc8),   32'(vt[i].fcnt));
      chk($sformatf("vec%0d_err", i),   32'(err8),  32'(vt[i].err));
    end

    // Counter saturation: 20 full LOW/HIGH cycles starting from HIGH
    for (int k = 0; k < 20; k++) begin
      hold(0, 1, 1, 0, 1, 6);
      hold(1, 0, 1, 0, 1, 6);
    end
    chk("sat_rcnt4", 32'(rc4), 32'(15));
    chk("sat_fcnt4", 32'(fc4), 32'(15));
    chk("sat_rcnt8", 32'(rc8), 32'(20));
    chk("sat_fcnt8", 32'(fc8), 32'(20));

    // Fault entry from HIGH, recovery to LOW, then clear coincident with a rise
    hold(1, 1, 1, 0, 1, 8);
    chk("flt_state", 32'(st4), 32'(3));
    chk("flt_err",   32'(err4), 32'(1));
    chk("flt_qf",    32'(qf4), 32'(1));
    hold(0, 1, 1, 0, 1, 8);
    chk("rec_state", 32'(st4), 32'(1));
    chk("rec_fcnt",  32'(fc4), 32'(15));
    hold(1, 0, 1, 0, 1, 5);
    hold(1, 0, 1, 1, 1, 1);
    chk("clr_rise4", 32'(rise4), 32'(1));
    chk("clr_rcnt4", 32'(rc4), 32'(1));
    chk("clr_rcnt8", 32'(rc8), 32'(1));
    chk("clr_fcnt4", 32'(fc4), 32'(0));
    chk("clr_err4",  32'(err4), 32'(0));

    // Randomized run, scored by the model every cycle
    for (int k = 0; k < 600; k++) begin
      int r;
      int n;
      logic [1:0] p;
      r = int'($urandom_range(0, 9));
      p = (r < 4) ? 2'b01 : (r < 8) ? 2'b10 : (r == 8) ? 2'b11 : 2'b00;
      n = int'($urandom_range(1, 8));
      for (int j = 0; j < n; j++) begin
        @(negedge C);
        Q_IN    = p[1];
        QBAR_IN = p[0];
        EN      = ($urandom_range(0, 9) != 0);
        CNT_CLR = ($urandom_range(0, 24) == 0);
        CLRB    = ($urandom_range(0, 199) != 0);
      end
    end

    @(negedge C);
    CLRB = 1'b1;
    @(posedge C);
    #3;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
